uart_transmitter: RTL and testbench
===================================

UART_TRANSMITTER -- requirements
Module: UART_transmitter

Interface
REQ-001 SHALL have parameter CLOCK_COUNTER_WIDTH, default 10, width of the per-bit clock counter.
REQ-002 SHALL have parameter BIT_COUNTER_WIDTH, default 3, width of the data-bit index counter.
REQ-003 SHALL have parameter DATA_WIDTH, default 8, data bits per frame.
REQ-004 SHALL have parameter CLOCKS_PER_BIT, default 434, i_clock cycles per serial bit.
REQ-005 SHALL have port i_clock  input  1  the single clock, rising edge.
REQ-006 SHALL have port i_reset  input  1  asynchronous, active-high reset.
REQ-007 SHALL have port i_data  input  DATA_WIDTH  byte to transmit.
REQ-008 SHALL have port i_valid  input  1  i_data is offered this cycle.
REQ-009 SHALL have port o_ready  output  1  holding register empty, so a byte can be accepted.
REQ-010 SHALL have port o_TX  output  1  serial line, idle high.
REQ-011 SHALL have port o_busy  output  1  a frame is on the line (any state except IDLE).
REQ-012 SHALL have port o_done  output  1  one-cycle pulse on the last cycle of each stop bit.

Function
REQ-013 SHALL frame as: start bit (0), DATA_WIDTH data bits LSB first, one stop bit (1); each bit lasts exactly CLOCKS_PER_BIT cycles.
REQ-014 SHALL accept a byte on any rising edge with i_valid && o_ready, writing it into a one-entry holding register; o_ready SHALL go low on the following cycle.
REQ-015 SHALL run FSM states IDLE, START, DATA, STOP; IDLE->START when holding full; START->DATA after CLOCKS_PER_BIT; DATA->STOP after the DATA_WIDTH-th bit; STOP->START if holding full at the end of the stop bit, else STOP->IDLE.
REQ-016 SHALL move the holding byte into the shift register on entry to START and free the holding register in the same cycle, so o_ready is high while a frame is shifting.
REQ-017 SHALL drive o_TX low on the first cycle after the IDLE->START transition, giving 1 cycle of latency from acceptance in IDLE to the start edge.
REQ-018 SHALL emit back-to-back frames with no idle cycles between the stop bit and the next start bit when a byte is held.
REQ-019 SHALL ignore i_valid while o_ready is low; i_data is not sampled.
REQ-020 SHALL count clocks 0..CLOCKS_PER_BIT-1 and wrap to 0 on each bit boundary; the bit index SHALL wrap from DATA_WIDTH-1 to 0 on the DATA->STOP transition.
REQ-021 SHALL, on a simultaneous accept and end of stop bit, take the newly accepted byte as the next frame (STOP->START).
REQ-022 SHALL register o_TX (glitch-free output).

Reset
REQ-023 SHALL, while i_reset is high, force: state IDLE, o_TX=1, o_ready=1, o_busy=0, o_done=0, counters 0, holding register empty.
REQ-024 SHALL abort any frame in progress when reset asserts mid-frame; o_TX returns high asynchronously and no o_done is produced for that frame.

Structure
REQ-025 SHALL take FSM state encodings and the default CLOCKS_PER_BIT/DATA_WIDTH constants from the shared UART defines file, which the receiver also uses.
REQ-026 SHALL use one sub-module, UART_bit_timer, containing the clock counter and producing a one-cycle bit-end strobe.

Verification
REQ-027 Send 8'h61 after reset -> o_TX sequence 0,1,0,0,0,0,1,1,0,1, each level held 434 cycles; o_done pulses once at cycle 4340 of the frame.
REQ-028 Offer 8'h61 and then 8'hA5 as soon as o_ready is high -> 20 contiguous bit periods with no gap; o_busy stays high throughout.
REQ-029 Hold i_valid high with 8'h3C while holding full -> o_ready low, byte unchanged, and 8'h3C is accepted only when o_ready rises.
REQ-030 Assert i_reset during data bit 3 -> o_TX=1 immediately, o_busy=0, o_ready=1, no o_done; a following byte transmits correctly.
REQ-031 Loop o_TX into UART_receiver_with_peripheral and send 8'h61 -> o_segment_2_digits displays "61".

Source files
------------

// File: rtl/uart_transmitter_pkg.sv
// Shared UART definitions: FSM state encoding, default frame constants
// and line levels used by both the transmitter and the receiver.
package uart_transmitter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } uart_state_t;

    localparam int UART_CLOCKS_PER_BIT = 434;
    localparam int UART_DATA_WIDTH     = 8;

    localparam logic UART_LINE_IDLE   = 1'b1;
    localparam logic UART_START_LEVEL = 1'b0;
    localparam logic UART_STOP_LEVEL  = 1'b1;

    // A frame occupies the line in every state except IDLE.
    function automatic logic uart_frame_active(uart_state_t s);
        return s != ST_IDLE;
    endfunction

endpackage

// File: rtl/uart_transmitter_bit_timer.sv
// Per-bit clock counter: counts 0..CLOCKS_PER_BIT-1 while enabled and
// raises a one-cycle strobe on the last cycle of every bit period.
module uart_transmitter_bit_timer #(
    parameter int CLOCK_COUNTER_WIDTH = 10,
    parameter int CLOCKS_PER_BIT      = 434
) (
    input  logic clock,
    input  logic reset,
    input  logic enable,
    output logic bit_end
);

    localparam logic [CLOCK_COUNTER_WIDTH-1:0] LAST_COUNT =
        CLOCK_COUNTER_WIDTH'(CLOCKS_PER_BIT - 1);

    logic [CLOCK_COUNTER_WIDTH-1:0] count;

    assign bit_end = enable && (count == LAST_COUNT);

    // Counter restarts at every bit boundary and is held at 0 while idle.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (!enable || bit_end) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/uart_transmitter.sv
// UART transmitter: one-entry holding register, start/data/stop framing,
// LSB first, back-to-back frames when a byte is waiting.
module uart_transmitter
    import uart_transmitter_pkg::*;
#(
    parameter int CLOCK_COUNTER_WIDTH = 10,
    parameter int BIT_COUNTER_WIDTH   = 3,
    parameter int DATA_WIDTH          = UART_DATA_WIDTH,
    parameter int CLOCKS_PER_BIT      = UART_CLOCKS_PER_BIT
) (
    input  logic                  i_clock,
    input  logic                  i_reset,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic                  i_valid,
    output logic                  o_ready,
    output logic                  o_TX,
    output logic                  o_busy,
    output logic                  o_done
);

    localparam logic [BIT_COUNTER_WIDTH-1:0] LAST_BIT =
        BIT_COUNTER_WIDTH'(DATA_WIDTH - 1);

    uart_state_t state;
    uart_state_t state_next;

    logic [DATA_WIDTH-1:0]        hold_data;
    logic                         hold_full;
    logic [DATA_WIDTH-1:0]        shift_data;
    logic [DATA_WIDTH-1:0]        load_data;
    logic [BIT_COUNTER_WIDTH-1:0] bit_index;
    logic                         tx_q;
    logic                         tx_next;
    logic                         bit_end;
    logic                         accept;
    logic                         last_bit;
    logic                         load;
    logic                         shift_en;

    assign o_ready  = !hold_full;
    assign accept   = i_valid && o_ready;
    assign last_bit = (bit_index == LAST_BIT);
    assign o_TX     = tx_q;

    // A byte accepted on the very edge that ends the stop bit bypasses
    // the holding register and becomes the next frame directly.
    assign load_data = hold_full ? hold_data : i_data;

    uart_transmitter_bit_timer #(
        .CLOCK_COUNTER_WIDTH (CLOCK_COUNTER_WIDTH),
        .CLOCKS_PER_BIT      (CLOCKS_PER_BIT)
    ) u_bit_timer (
        .clock   (i_clock),
        .reset   (i_reset),
        .enable  (uart_frame_active(state)),
        .bit_end (bit_end)
    );

    // FSM state register.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: advance on bit boundaries, chain frames when full.
    always_comb begin
        state_next = state;
        unique case (state)
            ST_IDLE: begin
                if (hold_full) begin
                    state_next = ST_START;
                end
            end
            ST_START: begin
                if (bit_end) begin
                    state_next = ST_DATA;
                end
            end
            ST_DATA: begin
                if (bit_end && last_bit) begin
                    state_next = ST_STOP;
                end
            end
            ST_STOP: begin
                if (bit_end) begin
                    if (hold_full || accept) begin
                        state_next = ST_START;
                    end else begin
                        state_next = ST_IDLE;
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Output/control logic: next line level, shifter load and shift.
    always_comb begin
        load     = 1'b0;
        shift_en = 1'b0;
        tx_next  = tx_q;
        o_busy   = uart_frame_active(state);
        o_done   = 1'b0;
        unique case (state)
            ST_IDLE: begin
                tx_next = UART_LINE_IDLE;
                if (hold_full) begin
                    load    = 1'b1;
                    tx_next = UART_START_LEVEL;
                end
            end
            ST_START: begin
                if (bit_end) begin
                    tx_next = shift_data[0];
                end
            end
            ST_DATA: begin
                if (bit_end) begin
                    if (last_bit) begin
                        tx_next = UART_STOP_LEVEL;
                    end else begin
                        shift_en = 1'b1;
                        tx_next  = shift_data[1];
                    end
                end
            end
            ST_STOP: begin
                if (bit_end) begin
                    o_done = 1'b1;
                    if (hold_full || accept) begin
                        load    = 1'b1;
                        tx_next = UART_START_LEVEL;
                    end else begin
                        tx_next = UART_LINE_IDLE;
                    end
                end
            end
            default: begin
                tx_next = UART_LINE_IDLE;
            end
        endcase
    end

    // Holding register: emptied when its byte moves into the shifter.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            hold_full <= 1'b0;
            hold_data <= '0;
        end else if (load) begin
            hold_full <= 1'b0;
        end else if (accept) begin
            hold_full <= 1'b1;
            hold_data <= i_data;
        end
    end

    // Shift register keeps the bit on the line at position 0.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            shift_data <= '0;
        end else if (load) begin
            shift_data <= load_data;
        end else if (shift_en) begin
            shift_data <= shift_data >> 1;
        end
    end

    // Data-bit index, wrapping to 0 as the last data bit ends.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            bit_index <= '0;
        end else if (state == ST_DATA && bit_end) begin
            bit_index <= last_bit ? '0 : bit_index + 1'b1;
        end
    end

    // Registered serial line, high while idle or in reset.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            tx_q <= UART_LINE_IDLE;
        end else begin
            tx_q <= tx_next;
        end
    end

endmodule

// File: tb/tb_uart_transmitter.sv
// Directed bench for uart_transmitter: table of single frames plus
// back-to-back, holding-register and mid-frame reset sequences.
module tb_uart_transmitter;

    localparam int CPB   = 434;
    localparam int FRAME = 10 * CPB;

    logic       clk = 1'b0;
    logic       rst;
    logic       valid;
    logic [7:0] data;
    logic       ready;
    logic       tx;
    logic       busy;
    logic       done;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [7:0] data;
        logic [9:0] frame;
    } vec_t;

    vec_t vecs[4];

    always #5 clk = ~clk;

    uart_transmitter dut (
        .i_clock (clk),
        .i_reset (rst),
        .i_data  (data),
        .i_valid (valid),
        .o_ready (ready),
        .o_TX    (tx),
        .o_busy  (busy),
        .o_done  (done)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Called on frame cycle 0 (first cycle of the start bit).
    task automatic check_frame(input string tag, input logic [9:0] f);
        int bad[10] = '{default: 0};
        int dones    = 0;
        int first    = -1;
        int busy_bad = 0;
        for (int c = 0; c < FRAME; c++) begin
            if (c > 0) step();
            if (tx !== f[c / CPB]) bad[c / CPB]++;
            if (done === 1'b1) begin
                dones++;
                if (first < 0) first = c + 1;
            end
            if (busy !== 1'b1) busy_bad++;
        end
        for (int b = 0; b < 10; b++)
            chk($sformatf("%s bit%0d bad cycles", tag, b), bad[b], 0);
        chk($sformatf("%s done cycle", tag), first, FRAME);
        chk($sformatf("%s done count", tag), dones, 1);
        chk($sformatf("%s busy low cycles", tag), busy_bad, 0);
    endtask

    task automatic check_idle(input string tag);
        chk($sformatf("%s idle tx", tag), tx, 1);
        chk($sformatf("%s idle busy", tag), busy, 0);
        chk($sformatf("%s idle ready", tag), ready, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int low;
        int done_seen;
        int tx_low;

        vecs[0] = '{8'h61, 10'b1011000010};
        vecs[1] = '{8'h00, 10'b1000000000};
        vecs[2] = '{8'hFF, 10'b1111111110};
        vecs[3] = '{8'h3C, 10'b1001111000};

        rst   = 1'b1;
        valid = 1'b0;
        data  = 8'h00;
        step();
        step();
        chk("reset tx", tx, 1);
        chk("reset ready", ready, 1);
        chk("reset busy", busy, 0);
        chk("reset done", done, 0);
        rst = 1'b0;
        step();
        check_idle("post reset");

        // Single frames from idle: accept, one cycle of latency, frame.
        for (int i = 0; i < 4; i++) begin
            data  = vecs[i].data;
            valid = 1'b1;
            step();
            valid = 1'b0;
            chk($sformatf("v%0d ready after accept", i), ready, 0);
            chk($sformatf("v%0d tx before start", i), tx, 1);
            step();
            check_frame($sformatf("v%0d", i), vecs[i].frame);
            step();
            check_idle($sformatf("v%0d", i));
        end

        // Back-to-back: second byte offered as soon as ready returns.
        data  = 8'h61;
        valid = 1'b1;
        step();
        chk("b2b ready low", ready, 0);
        data = 8'hA5;
        step();
        chk("b2b ready freed at start", ready, 1);
        fork
            begin
                check_frame("b2b 61", 10'b1011000010);
                step();
                check_frame("b2b A5", 10'b1101001010);
            end
            begin
                step();
                valid = 1'b0;
                chk("b2b second held", ready, 0);
            end
        join
        step();
        check_idle("b2b");

        // Holding register full: 3C must wait until the held byte leaves.
        data  = 8'hFF;
        valid = 1'b1;
        step();
        data = 8'h00;
        step();
        fork
            begin
                check_frame("hold FF", 10'b1111111110);
                step();
                check_frame("hold 00", 10'b1000000000);
                step();
                check_frame("hold 3C", 10'b1001111000);
            end
            begin
                step();
                data = 8'h3C;
                low  = 0;
                while (ready !== 1'b1 && low < 2 * FRAME) begin
                    low++;
                    step();
                end
                chk("hold ready low cycles", low, FRAME - 1);
                step();
                valid = 1'b0;
                chk("hold 3C accepted", ready, 0);
            end
        join
        step();
        check_idle("hold");

        // Reset during data bit 3 of 0x61.
        data  = 8'h61;
        valid = 1'b1;
        step();
        valid = 1'b0;
        step();
        repeat (1900) step();
        chk("abort pre-reset tx", tx, 0);
        #2;
        rst = 1'b1;
        #1;
        chk("abort tx async", tx, 1);
        chk("abort busy", busy, 0);
        chk("abort ready", ready, 1);
        done_seen = 0;
        if (done === 1'b1) done_seen++;
        repeat (3) begin
            step();
            if (done === 1'b1) done_seen++;
        end
        rst = 1'b0;
        tx_low = 0;
        repeat (2 * CPB) begin
            step();
            if (done === 1'b1) done_seen++;
            if (tx !== 1'b1) tx_low++;
        end
        chk("abort no done", done_seen, 0);
        chk("abort line stays idle", tx_low, 0);
        check_idle("abort");
        data  = 8'hA5;
        valid = 1'b1;
        step();
        valid = 1'b0;
        step();
        check_frame("after abort", 10'b1101001010);
        step();
        check_idle("after abort");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
